cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of each statistics counter.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req_valid  input  1  CPU request present; tag/index/blk_offset/data_in held stable by CPU until cpu_resp_valid.
REQ-005 SHALL have port cpu_req_type  input  1  0 = read, 1 = write.
REQ-006 SHALL have port cpu_req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port cpu_resp_valid  output  1  one-cycle pulse: request completed.
REQ-008 SHALL have port hit  input  1  hit flag from cache_memory.
REQ-009 SHALL have port dirty_bit  input  1  dirty flag of the victim way from cache_memory.
REQ-010 SHALL have port mem_ready  input  1  main memory has completed the current block transfer.
REQ-011 SHALL have port req_type  output  1  latched request type, driven to cache_memory.
REQ-012 SHALL have ports read_en_cache, write_en_cache, read_en_mem, write_en_mem  output  1 each  cache_memory/memory strobes.
REQ-013 SHALL have port clr_stats  input  1  synchronous clear of all counters.
REQ-014 SHALL have ports hit_cnt, miss_cnt, wb_cnt  output  CNT_WIDTH each  statistics.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, COMPARE, ACCESS, WRITE_BACK, ALLOCATE; all strobe outputs decoded from state only.
REQ-016 IDLE: cpu_req_ready=1, all strobes 0; on cpu_req_valid, latch cpu_req_type into req_type, clear retry flag, go COMPARE.
REQ-017 cpu_req_ready SHALL be 0 in every state other than IDLE; cpu_req_valid ignored outside IDLE.
REQ-018 COMPARE: all strobes 0; sample hit: hit -> ACCESS; miss & dirty_bit -> WRITE_BACK; miss & !dirty_bit -> ALLOCATE.
REQ-019 ACCESS: read_en_cache=~req_type, write_en_cache=req_type, cpu_resp_valid=1, for exactly one cycle; next state IDLE.
REQ-020 WRITE_BACK: read_en_cache=1, write_en_mem=1 held every cycle; on mem_ready=1 (including first cycle) go ALLOCATE.
REQ-021 ALLOCATE: read_en_mem=1, write_en_cache=1 held every cycle; on mem_ready=1 set retry flag, go COMPARE.
REQ-022 mem_ready SHALL be ignored in IDLE, COMPARE, ACCESS.
REQ-023 Hit latency: acceptance edge -> COMPARE (1 cycle) -> ACCESS with cpu_resp_valid in the 2nd cycle after acceptance.
REQ-024 Miss in COMPARE with retry flag set SHALL still follow REQ-018 (no hang-up special case); retry flag only gates counters.
REQ-025 hit_cnt SHALL increment on leaving COMPARE with hit=1 and retry=0; miss_cnt on leaving COMPARE with hit=0 and retry=0; wb_cnt on leaving WRITE_BACK.
REQ-026 Counters SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-027 clr_stats=1 SHALL zero all counters next edge; clear wins over a simultaneous increment.
REQ-028 FSM SHALL not change state or strobes in response to clr_stats.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, retry=0, req_type=0, all strobes 0, cpu_resp_valid=0, counters 0, cpu_req_ready=1, regardless of state.
REQ-030 Reset mid WRITE_BACK/ALLOCATE SHALL drop write_en_mem/read_en_mem asynchronously; no transfer completion is recorded.

Verification
REQ-031 Read hit: valid=1,type=0, hit=1 -> read_en_cache and cpu_resp_valid high in cycle 2 after acceptance for 1 cycle; hit_cnt=1.
REQ-032 Write miss clean: type=1, hit=0, dirty_bit=0, mem_ready after 2 ALLOCATE cycles, hit=1 on retry -> ALLOCATE 3 cycles, then COMPARE, ACCESS with write_en_cache; miss_cnt=1, hit_cnt=0.
REQ-033 Write miss dirty: hit=0, dirty_bit=1, mem_ready after 3 cycles each phase -> WRITE_BACK 4 cycles, ALLOCATE 4 cycles, ACCESS; wb_cnt=1, miss_cnt=1.
REQ-034 Reset asserted in 2nd WRITE_BACK cycle -> write_en_mem=0 same cycle, cpu_req_ready=1, counters 0; next request processed normally.
REQ-035 CNT_WIDTH=2, five read hits -> hit_cnt stays 3; clr_stats with sixth hit in COMPARE -> hit_cnt=0.
REQ-036 cpu_req_valid held high through a hit -> second request accepted only in the IDLE cycle after cpu_resp_valid.

Source files
------------

// File: rtl/cache_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_controller : Moore FSM sequencing cache/memory strobes, with saturating
// hit/miss/write-back statistics.                                   Rev 1.0
// ----------------------------------------------------------------------------
module cache_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_type,
  output logic                 cpu_req_ready,
  output logic                 cpu_resp_valid,
  input  logic                 hit,
  input  logic                 dirty_bit,
  input  logic                 mem_ready,
  output logic                 req_type,
  output logic                 read_en_cache,
  output logic                 write_en_cache,
  output logic                 read_en_mem,
  output logic                 write_en_mem,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COMPARE    = 3'd1,
    S_ACCESS     = 3'd2,
    S_WRITE_BACK = 3'd3,
    S_ALLOCATE   = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   retry_q;
  logic   req_type_q;
  logic   ready_q, resp_q;
  logic   rd_cache_q, wr_cache_q, rd_mem_q, wr_mem_q;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic hit_inc, miss_inc, wb_inc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (cpu_req_valid) state_d = S_COMPARE;
      S_COMPARE: begin
        if (hit)            state_d = S_ACCESS;
        else if (dirty_bit) state_d = S_WRITE_BACK;
        else                state_d = S_ALLOCATE;
      end
      S_ACCESS:     state_d = S_IDLE;
      S_WRITE_BACK: if (mem_ready) state_d = S_ALLOCATE;
      S_ALLOCATE:   if (mem_ready) state_d = S_COMPARE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      retry_q    <= 1'b0;
      req_type_q <= 1'b0;
      ready_q    <= 1'b1;
      resp_q     <= 1'b0;
      rd_cache_q <= 1'b0;
      wr_cache_q <= 1'b0;
      rd_mem_q   <= 1'b0;
      wr_mem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu_req_valid) begin
        req_type_q <= cpu_req_type;
        retry_q    <= 1'b0;
      end else if (state_q == S_ALLOCATE && mem_ready) begin
        retry_q <= 1'b1;
      end
      ready_q    <= (state_d == S_IDLE);
      resp_q     <= (state_d == S_ACCESS);
      rd_cache_q <= (state_d == S_ACCESS && !req_type_q) || (state_d == S_WRITE_BACK);
      wr_cache_q <= (state_d == S_ACCESS &&  req_type_q) || (state_d == S_ALLOCATE);
      rd_mem_q   <= (state_d == S_ALLOCATE);
      wr_mem_q   <= (state_d == S_WRITE_BACK);
    end
  end

  // Retried compares follow a fill and must not be counted a second time.
  assign hit_inc  = (state_q == S_COMPARE) &&  hit && !retry_q;
  assign miss_inc = (state_q == S_COMPARE) && !hit && !retry_q;
  assign wb_inc   = (state_q == S_WRITE_BACK) && mem_ready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && v != CNT_MAX) ? v + CNT_ONE : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (clr_stats) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= sat_inc(hit_cnt_q, hit_inc);
      miss_cnt_q <= sat_inc(miss_cnt_q, miss_inc);
      wb_cnt_q   <= sat_inc(wb_cnt_q, wb_inc);
    end
  end

  assign cpu_req_ready  = ready_q;
  assign cpu_resp_valid = resp_q;
  assign req_type       = req_type_q;
  assign read_en_cache  = rd_cache_q;
  assign write_en_cache = wr_cache_q;
  assign read_en_mem    = rd_mem_q;
  assign write_en_mem   = wr_mem_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  assign wb_cnt         = wb_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// tb_cache_controller : vector table, hand sequences and randomized transactions
// checked against a transaction-level latency/statistics model.
module tb_cache_controller;
  localparam int SAT_W = 2;

  logic clk = 1'b0, rst_n = 1'b1;
  logic cpu_req_valid = 1'b0, cpu_req_type = 1'b0;
  logic hit = 1'b0, dirty_bit = 1'b0, mem_ready = 1'b0, clr_stats = 1'b0;
  logic cpu_req_ready, cpu_resp_valid, req_type;
  logic read_en_cache, write_en_cache, read_en_mem, write_en_mem;
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
  logic s_ready, s_resp, s_rt, s_rc, s_wc, s_rm, s_wm;
  logic [SAT_W-1:0] s_hit, s_miss, s_wb;

  int n_cmp = 0, n_bad = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;

  cache_controller dut (
    .clk(clk), .rst_n(rst_n), .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid), .hit(hit),
    .dirty_bit(dirty_bit), .mem_ready(mem_ready), .req_type(req_type),
    .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem), .clr_stats(clr_stats),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt));

  cache_controller #(.CNT_WIDTH(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type),
    .cpu_req_ready(s_ready), .cpu_resp_valid(s_resp), .hit(hit),
    .dirty_bit(dirty_bit), .mem_ready(mem_ready), .req_type(s_rt),
    .read_en_cache(s_rc), .write_en_cache(s_wc),
    .read_en_mem(s_rm), .write_en_mem(s_wm), .clr_stats(clr_stats),
    .hit_cnt(s_hit), .miss_cnt(s_miss), .wb_cnt(s_wb));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit t, h, d;
    int wl, al;
    int e_resp, e_wb, e_al;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Latency from the acceptance edge to the ACCESS cycle, from the phase lengths.
  function automatic int exp_lat(input bit h, input bit d, input int wl, input int al);
    if (h) return 2;
    return 1 + (d ? wl + 1 : 0) + (al + 1) + 2;
  endfunction

  task automatic model_txn(input bit h, input bit d, input bit clr);
    if (clr) begin
      m_hit = 0; m_miss = 0; m_wb = 0;
    end else begin
      if (h) m_hit++; else m_miss++;
      if (!h && d) m_wb++;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, " hit_cnt"},  hit_cnt,  sat(m_hit, 65535));
    chk({tag, " miss_cnt"}, miss_cnt, sat(m_miss, 65535));
    chk({tag, " wb_cnt"},   wb_cnt,   sat(m_wb, 65535));
    chk({tag, " sat_hit"},  s_hit,    sat(m_hit, 3));
    chk({tag, " sat_miss"}, s_miss,   sat(m_miss, 3));
    chk({tag, " sat_wb"},   s_wb,     sat(m_wb, 3));
  endtask

  // Acts as CPU plus cache/memory responder for one request.
  task automatic run_txn(input bit t, input bit h, input bit d, input int wl, input int al,
                         input bit clr_cmp, output int resp_c, output int wbn, output int aln,
                         output bit rdc, output bit wrc, output bit rt);
    bit alloc_done, filled;
    int ready_bad;
    @(negedge clk);
    chk("idle_ready", cpu_req_ready, 1);
    chk("idle_resp_low", cpu_resp_valid, 0);
    cpu_req_valid = 1'b1; cpu_req_type = t; hit = h; dirty_bit = d; mem_ready = 1'b0;
    resp_c = -1; wbn = 0; aln = 0; rdc = 0; wrc = 0; rt = 0;
    alloc_done = 0; filled = 0; ready_bad = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      cpu_req_valid = 1'b0;
      clr_stats = clr_cmp && (c == 1);
      if (alloc_done) filled = 1;
      hit = filled ? 1'b1 : h;
      mem_ready = 1'b0;
      alloc_done = 0;
      if (cpu_req_ready) ready_bad++;
      if (write_en_mem) begin wbn++; mem_ready = (wbn == wl + 1); end
      if (read_en_mem) begin aln++; mem_ready = (aln == al + 1); alloc_done = mem_ready; end
      if (cpu_resp_valid) begin
        resp_c = c; rdc = read_en_cache; wrc = write_en_cache; rt = req_type;
        break;
      end
    end
    clr_stats = 1'b0;
    mem_ready = 1'b0;
    chk("busy_ready_low", ready_bad, 0);
  endtask

  task automatic do_txn(input string tag, input bit t, input bit h, input bit d,
                        input int wl, input int al, input int e_resp, input int e_wb,
                        input int e_al, input bit clr);
    int rc, wbn, aln;
    bit rdc, wrc, rt;
    run_txn(t, h, d, wl, al, clr, rc, wbn, aln, rdc, wrc, rt);
    model_txn(h, d, clr);
    chk({tag, " resp_cycle"}, rc, e_resp);
    chk({tag, " wb_cycles"}, wbn, e_wb);
    chk({tag, " alloc_cycles"}, aln, e_al);
    chk({tag, " read_en_cache"}, rdc, !t);
    chk({tag, " write_en_cache"}, wrc, t);
    chk({tag, " req_type"}, rt, t);
    check_counts(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst ready", cpu_req_ready, 1);
    chk("rst strobes", {read_en_cache, write_en_cache, read_en_mem, write_en_mem, cpu_resp_valid}, 0);
    m_hit = 0; m_miss = 0; m_wb = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    int seen;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 0, 0, 2, 0, 0};   // read hit
    vecs[1] = '{1'b1, 1'b1, 1'b0, 0, 0, 2, 0, 0};   // write hit
    vecs[2] = '{1'b1, 1'b0, 1'b0, 0, 2, 6, 0, 3};   // write miss clean
    vecs[3] = '{1'b1, 1'b0, 1'b1, 3, 3, 11, 4, 4};  // write miss dirty
    vecs[4] = '{1'b0, 1'b0, 1'b1, 0, 0, 5, 1, 1};   // mem_ready on first cycle
    vecs[5] = '{1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2, 2, 2, 0, 0};   // dirty ignored on hit

    #3 rst_n = 1'b0;
    #1;
    chk("por ready", cpu_req_ready, 1);
    chk("por strobes", {read_en_cache, write_en_cache, read_en_mem, write_en_mem, cpu_resp_valid}, 0);
    chk("por req_type", req_type, 0);
    check_counts("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].h, vecs[i].d, vecs[i].wl,
             vecs[i].al, vecs[i].e_resp, vecs[i].e_wb, vecs[i].e_al, 1'b0);

    // Reset in the second WRITE_BACK cycle.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_type = 1'b1; hit = 1'b0; dirty_bit = 1'b1; mem_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      cpu_req_valid = 1'b0;
      if (write_en_mem) seen++;
    end
    chk("midwb reached", seen, 2);
    rst_n = 1'b0;
    #1;
    chk("midwb write_en_mem", write_en_mem, 0);
    chk("midwb read_en_cache", read_en_cache, 0);
    chk("midwb ready", cpu_req_ready, 1);
    m_hit = 0; m_miss = 0; m_wb = 0;
    check_counts("midwb");
    @(negedge clk);
    rst_n = 1'b1;
    do_txn("after_rst", 1'b0, 1'b1, 1'b0, 0, 0, 2, 0, 0, 1'b0);

    // Valid held through a hit: next acceptance only from the IDLE cycle.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; hit = 1'b1; dirty_bit = 1'b0;
    @(negedge clk); chk("hold c1 ready", cpu_req_ready, 0);
    @(negedge clk); chk("hold c2 resp", cpu_resp_valid, 1); chk("hold c2 ready", cpu_req_ready, 0);
    @(negedge clk); chk("hold c3 ready", cpu_req_ready, 1); chk("hold c3 resp", cpu_resp_valid, 0);
    @(negedge clk); chk("hold c4 ready", cpu_req_ready, 0); cpu_req_valid = 1'b0;
    @(negedge clk); chk("hold c5 resp", cpu_resp_valid, 1);
    m_hit += 2;
    check_counts("hold");

    // Saturation of the narrow instance, then clear racing a hit.
    pulse_reset();
    for (int i = 0; i < 5; i++)
      do_txn($sformatf("sat%0d", i), 1'b0, 1'b1, 1'b0, 0, 0, 2, 0, 0, 1'b0);
    chk("sat narrow hit_cnt", s_hit, 3);
    do_txn("clr_race", 1'b0, 1'b1, 1'b0, 0, 0, 2, 0, 0, 1'b1);
    chk("clr narrow hit_cnt", s_hit, 0);

    for (int i = 0; i < 40; i++) begin
      bit t, h, d;
      int wl, al;
      t = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      wl = $urandom_range(0, 4);
      al = $urandom_range(0, 4);
      do_txn($sformatf("rnd%0d", i), t, h, d, wl, al, exp_lat(h, d, wl, al),
             (!h && d) ? wl + 1 : 0, h ? 0 : al + 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
